// File: rtl/alu_pkg.sv
// Shared ALU operation codes and the MUL sequencer state encoding.
// Imported by the ALU and by the multiply sequencer.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1110;
    localparam logic [3:0] ALU_SRL = 4'b1111;
    localparam logic [3:0] ALU_LUI = 4'b1011;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADD  = 3'd1,
        SHL  = 3'd2,
        SHR  = 3'd3,
        DONE = 3'd4
    } mul_state_t;

endpackage

// File: rtl/alu.sv
// Shared combinational ALU used by the execute stage and the MUL sequencer.
// Shift amounts come from SrcB[4:0], so DATA_WIDTH is fixed at 32.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    ALUResult
);

    // Operation decode; unknown codes produce zero.
    always_comb begin
        ALUResult = {DATA_WIDTH{1'b0}};
        case (Operation)
            ALU_AND: ALUResult = SrcA & SrcB;
            ALU_OR:  ALUResult = SrcA | SrcB;
            ALU_ADD: ALUResult = SrcA + SrcB;
            ALU_XOR: ALUResult = SrcA ^ SrcB;
            ALU_SUB: ALUResult = SrcA - SrcB;
            ALU_SLL: ALUResult = SrcA << SrcB[4:0];
            ALU_SRL: ALUResult = SrcA >> SrcB[4:0];
            ALU_SRA: ALUResult = $signed(SrcA) >>> SrcB[4:0];
            ALU_LUI: ALUResult = SrcB;
            default: ALUResult = {DATA_WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle shift-add sequencer for RV32M MUL (low product half), driving the
// shared ALU through ADD/SHL/SHR steps for a fixed 3*DATA_WIDTH-cycle latency.
module mul_seq_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] ZERO = {DATA_WIDTH{1'b0}};

    mul_state_t               state_q, state_d;
    logic [DATA_WIDTH-1:0]    acc_q, acc_d;
    logic [DATA_WIDTH-1:0]    mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0]    mplier_q, mplier_d;
    logic [DATA_WIDTH-1:0]    result_q, result_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     busy_q, done_q;

    logic [DATA_WIDTH-1:0]    alu_src_a, alu_src_b, alu_res;
    logic [OPCODE_LENGTH-1:0] alu_op;

    // State-indexed ALU input mux; IDLE/DONE park the ALU on 0+0.
    always_comb begin
        alu_op    = OPCODE_LENGTH'(ALU_ADD);
        alu_src_a = ZERO;
        alu_src_b = ZERO;
        case (state_q)
            ADD: begin
                alu_op    = OPCODE_LENGTH'(ALU_ADD);
                alu_src_a = acc_q;
                alu_src_b = mplier_q[0] ? mcand_q : ZERO;
            end
            SHL: begin
                alu_op    = OPCODE_LENGTH'(ALU_SLL);
                alu_src_a = mcand_q;
                alu_src_b = ONE;
            end
            SHR: begin
                alu_op    = OPCODE_LENGTH'(ALU_SRL);
                alu_src_a = mplier_q;
                alu_src_b = ONE;
            end
            default: begin
                alu_op    = OPCODE_LENGTH'(ALU_ADD);
                alu_src_a = ZERO;
                alu_src_b = ZERO;
            end
        endcase
    end

    alu #(
        .DATA_WIDTH    (DATA_WIDTH),
        .OPCODE_LENGTH (OPCODE_LENGTH)
    ) u_alu (
        .SrcA      (alu_src_a),
        .SrcB      (alu_src_b),
        .Operation (alu_op),
        .ALUResult (alu_res)
    );

    // Next-state and datapath update; exactly one datapath register moves per step.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d    = ZERO;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    cnt_d    = {CNT_W{1'b0}};
                    state_d  = ADD;
                end else begin
                    state_d  = IDLE;
                end
            end
            ADD: begin
                acc_d   = alu_res;
                state_d = SHL;
            end
            SHL: begin
                mcand_d = alu_res;
                state_d = SHR;
            end
            SHR: begin
                mplier_d = alu_res;
                if (cnt_q == CNT_LAST) begin
                    result_d = acc_q;
                    state_d  = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = ADD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered status flags; reset drops any in-flight op.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= ZERO;
            mcand_q  <= ZERO;
            mplier_q <= ZERO;
            result_q <= ZERO;
            cnt_q    <= {CNT_W{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            busy_q   <= (state_d != IDLE);
            done_q   <= (state_d == DONE);
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed self-checking bench for mul_seq_ctrl: latency, wrap-around products,
// ignored starts, result hold and mid-operation reset.
module tb_mul_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int pass_cnt;
    int total_cnt;

    // Observations from the most recent run_op.
    logic        obs_busy1;
    int          obs_done_cyc;
    int          obs_pulses;
    logic [31:0] obs_res_done;
    logic [31:0] obs_res_mid;
    logic        obs_rst_busy;
    logic        obs_rst_done;
    logic [31:0] obs_rst_res;

    mul_seq_ctrl #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start an op, then watch 110 cycles. Cycle c is the one after accept edge c.
    // Extra starts (9*9) are pulsed in cycles i1/i2/i3; reset is pulsed in cycle rst_at.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int i1, input int i2, input int i3, input int rst_at);
        obs_busy1 = 1'b0; obs_done_cyc = 0; obs_pulses = 0;
        obs_res_done = 32'h0; obs_res_mid = 32'h0;
        obs_rst_busy = 1'b1; obs_rst_done = 1'b1; obs_rst_res = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b;
        for (int c = 1; c <= 110; c++) begin
            @(negedge clk);
            if (c == 1) obs_busy1 = busy;
            if (c == 50) obs_res_mid = result;
            if (done) begin
                obs_pulses++;
                if (obs_done_cyc == 0) begin
                    obs_done_cyc = c;
                    obs_res_done = result;
                end
            end
            if (rst_at > 0 && c == rst_at + 1) begin
                obs_rst_busy = busy; obs_rst_done = done; obs_rst_res = result;
            end
            if (c == i1 || c == i2 || c == i3) begin
                start = 1'b1; op_a = 32'd9; op_b = 32'd9;
            end else begin
                start = 1'b0;
            end
            reset = (c == rst_at) ? 1'b1 : 1'b0;
        end
        start = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; op_a = 32'h0; op_b = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
        total_cnt++;
        if (result !== 32'h0) $display("FAIL reset_result: got %h want 0", result); else pass_cnt++;
    endtask

    task automatic test_basic;
        run_op(32'd6, 32'd7, 0, 0, 0, 0);
        total_cnt++;
        if (obs_busy1 !== 1'b1) $display("FAIL basic_busy1: got %b want 1", obs_busy1); else pass_cnt++;
        total_cnt++;
        if (obs_done_cyc != 97) $display("FAIL basic_latency: got %0d want 97", obs_done_cyc); else pass_cnt++;
        total_cnt++;
        if (obs_pulses != 1) $display("FAIL basic_pulses: got %0d want 1", obs_pulses); else pass_cnt++;
        total_cnt++;
        if (obs_res_done !== 32'd42) $display("FAIL basic_result: got %h want 2a", obs_res_done); else pass_cnt++;
        total_cnt++;
        if (result !== 32'd42 || busy !== 1'b0)
            $display("FAIL basic_hold: got %h busy %b want 2a busy 0", result, busy);
        else pass_cnt++;
    endtask

    task automatic test_wrap;
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [31:0] ve [3];
        va[0] = 32'hFFFFFFFF; vb[0] = 32'hFFFFFFFF; ve[0] = 32'h00000001;
        va[1] = 32'hFFFFFFFD; vb[1] = 32'd5;        ve[1] = 32'hFFFFFFF1;
        va[2] = 32'h80000000; vb[2] = 32'd2;        ve[2] = 32'h00000000;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], 0, 0, 0, 0);
            total_cnt++;
            if (obs_res_done !== ve[i] || obs_done_cyc != 97)
                $display("FAIL wrap_%0d: got %h at cycle %0d want %h at 97", i, obs_res_done, obs_done_cyc, ve[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_zero;
        run_op(32'h0, 32'h12345678, 0, 0, 0, 0);
        total_cnt++;
        if (obs_res_done !== 32'h0) $display("FAIL zero_result: got %h want 0", obs_res_done); else pass_cnt++;
        total_cnt++;
        if (obs_done_cyc != 97) $display("FAIL zero_latency: got %0d want 97", obs_done_cyc); else pass_cnt++;
    endtask

    task automatic test_hold_back_to_back;
        run_op(32'd6, 32'd7, 0, 0, 0, 0);
        run_op(32'd3, 32'd4, 0, 0, 0, 0);
        total_cnt++;
        if (obs_res_mid !== 32'd42) $display("FAIL hold_mid: got %h want 2a", obs_res_mid); else pass_cnt++;
        total_cnt++;
        if (obs_res_done !== 32'd12 || obs_done_cyc != 97)
            $display("FAIL back_to_back: got %h at cycle %0d want c at 97", obs_res_done, obs_done_cyc);
        else pass_cnt++;
    endtask

    task automatic test_ignored_start;
        run_op(32'd6, 32'd7, 10, 96, 97, 0);
        total_cnt++;
        if (obs_res_done !== 32'd42) $display("FAIL ignore_result: got %h want 2a", obs_res_done); else pass_cnt++;
        total_cnt++;
        if (obs_pulses != 1 || obs_done_cyc != 97)
            $display("FAIL ignore_pulses: got %0d pulses first at %0d want 1 at 97", obs_pulses, obs_done_cyc);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0 || result !== 32'd42)
            $display("FAIL ignore_no_queue: got busy %b result %h want busy 0 result 2a", busy, result);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        run_op(32'd6, 32'd7, 0, 0, 0, 40);
        total_cnt++;
        if (obs_rst_busy !== 1'b0 || obs_rst_done !== 1'b0 || obs_rst_res !== 32'h0)
            $display("FAIL midreset_state: got busy %b done %b result %h want 0 0 0",
                     obs_rst_busy, obs_rst_done, obs_rst_res);
        else pass_cnt++;
        total_cnt++;
        if (obs_pulses != 0) $display("FAIL midreset_nodone: got %0d pulses want 0", obs_pulses); else pass_cnt++;
        run_op(32'd3, 32'd4, 0, 0, 0, 0);
        total_cnt++;
        if (obs_res_done !== 32'd12 || obs_done_cyc != 97)
            $display("FAIL midreset_fresh: got %h at cycle %0d want c at 97", obs_res_done, obs_done_cyc);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        reset = 1'b1; start = 1'b0; op_a = 32'h0; op_b = 32'h0;
        test_reset();
        test_basic();
        test_wrap();
        test_zero();
        test_hold_back_to_back();
        test_ignored_start();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
